// File: rtl/bus_controller_rr_pkg.sv
// Shared types for the round-robin bus controller: FSM states, the request
// record and a width helper for counters and channel indices.
package bus_pkg;

   localparam int BUS_ADDR_WIDTH = 32;
   localparam int BUS_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESPOND
   } bus_state_t;

   typedef struct packed {
      logic                      write_enable;
      logic [BUS_ADDR_WIDTH-1:0] address;
      logic [BUS_DATA_WIDTH-1:0] data_write;
   } bus_request_t;

   // Bits needed to hold 0..max_value, never less than one.
   function automatic int bits_for(input int max_value);
      return (max_value < 2) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/bus_controller_rr_if.sv
// Requester-side and memory-side signals of the bus controller. The
// controller is the slave; requesters and the memory model form the master.
interface bus_controller_rr_if #(
   parameter int CHANNELS   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic [CHANNELS-1:0]                 req_vaild;
   logic [CHANNELS-1:0]                 req_write_enable;
   logic [CHANNELS-1:0][ADDR_WIDTH-1:0] req_address;
   logic [CHANNELS-1:0][DATA_WIDTH-1:0] req_data_write;
   logic [CHANNELS-1:0]                 req_ready;
   logic                                req_error;
   logic [DATA_WIDTH-1:0]               req_data_read;

   logic                                mem_vaild;
   logic                                mem_ready;
   logic                                mem_write_enable;
   logic [ADDR_WIDTH-1:0]               mem_address;
   logic [DATA_WIDTH-1:0]               mem_data_write;
   logic [DATA_WIDTH-1:0]               mem_data_read;

   logic                                bus_busy;

   modport slave (
      input  req_vaild, req_write_enable, req_address, req_data_write,
      input  mem_ready, mem_data_read,
      output req_ready, req_error, req_data_read,
      output mem_vaild, mem_write_enable, mem_address, mem_data_write,
      output bus_busy
   );

   modport master (
      output req_vaild, req_write_enable, req_address, req_data_write,
      output mem_ready, mem_data_read,
      input  req_ready, req_error, req_data_read,
      input  mem_vaild, mem_write_enable, mem_address, mem_data_write,
      input  bus_busy
   );

endinterface

// File: rtl/bus_controller_rr_arbiter.sv
// Combinational round-robin picker: the search starts one above the last
// granted channel and wraps, so every requester is served in turn.
module round_robin_arbiter
   import bus_pkg::*;
#(
   parameter  int CHANNELS = 2,
   localparam int IDX_W    = bits_for(CHANNELS - 1)
) (
   input  logic [CHANNELS-1:0] request,
   input  logic [IDX_W-1:0]    last_grant,
   input  logic                enable,
   output logic                grant_valid,
   output logic [IDX_W-1:0]    grant_index
);

   always_comb begin
      int candidate;
      grant_valid = 1'b0;
      grant_index = '0;
      candidate   = 0;
      for (int offset = 1; offset <= CHANNELS; offset++) begin
         candidate = (int'(last_grant) + offset) % CHANNELS;
         if (enable && !grant_valid && request[IDX_W'(candidate)]) begin
            grant_valid = 1'b1;
            grant_index = IDX_W'(candidate);
         end
      end
   end

endmodule

// File: rtl/bus_controller_rr.sv
// Multi-channel bus controller: round-robin grant, one registered memory
// transaction at a time, per-transaction timeout reported as an error.
module bus_controller_rr
   import bus_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 15
) (
   input  logic              clock,
   input  logic              reset,
   bus_controller_rr_if.slave bus
);

   localparam int              IDX_W     = bits_for(CHANNELS - 1);
   localparam int              CNT_W     = bits_for(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(CHANNELS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);

   bus_state_t              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        grant_q, grant_d;
   logic [IDX_W-1:0]        last_grant_q, last_grant_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [CHANNELS-1:0]     ready_q, ready_d;
   logic                    error_q, error_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    mem_vaild_q, mem_vaild_d;
   logic                    busy_q, busy_d;

   logic                    grant_valid;
   logic [IDX_W-1:0]        grant_index;

   round_robin_arbiter #(.CHANNELS(CHANNELS)) u_arbiter (
      .request     (bus.req_vaild),
      .last_grant  (last_grant_q),
      .enable      (state_q == IDLE),
      .grant_valid (grant_valid),
      .grant_index (grant_index)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ready_d      = '0;
      error_d      = 1'b0;
      rdata_d      = rdata_q;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               grant_d      = grant_index;
               last_grant_d = grant_index;
               we_d         = bus.req_write_enable[grant_index];
               addr_d       = bus.req_address[grant_index];
               wdata_d      = bus.req_data_write[grant_index];
               cnt_d        = '0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            // A completion in the same cycle as the timeout takes priority.
            if (bus.mem_ready) begin
               rdata_d          = we_q ? '0 : bus.mem_data_read;
               ready_d[grant_q] = 1'b1;
               state_d          = RESPOND;
            end else if (TIMEOUT != 0 && cnt_q == CNT_MAX) begin
               rdata_d          = '0;
               error_d          = 1'b1;
               ready_d[grant_q] = 1'b1;
               state_d          = RESPOND;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      mem_vaild_d = (state_d == ISSUE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         grant_q      <= '0;
         last_grant_q <= LAST_INIT;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ready_q      <= '0;
         error_q      <= 1'b0;
         rdata_q      <= '0;
         mem_vaild_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ready_q      <= ready_d;
         error_q      <= error_d;
         rdata_q      <= rdata_d;
         mem_vaild_q  <= mem_vaild_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.req_ready        = ready_q;
   assign bus.req_error        = error_q;
   assign bus.req_data_read    = rdata_q;
   assign bus.mem_vaild        = mem_vaild_q;
   assign bus.mem_write_enable = we_q;
   assign bus.mem_address      = addr_q;
   assign bus.mem_data_write   = wdata_q;
   assign bus.bus_busy         = busy_q;

endmodule

// File: doc/bus_controller_rr.md
# bus_controller_rr

Parametrised successor to the single-port bus controller. It arbitrates between `CHANNELS` requesters (instruction fetch, data access, …) onto one memory/ROM port using round-robin. Each transaction is a registered valid/ready handshake on both sides, with a per-transaction timeout that returns an error instead of hanging the core. It sits between the CPU front-end/execution units and the BIOS ROM / memory interface.

## Interface

Parameters:
- `CHANNELS`, default 2: number of requester channels (≥1).
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `TIMEOUT`, default 15: maximum cycles to wait for `mem_ready`; 0 disables the timeout.

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low (0 = reset).
- `req_vaild`, in, `CHANNELS`: per-channel request.
- `req_write_enable`, in, `CHANNELS`: per-channel write (1) / read (0).
- `req_address`, in, `CHANNELS`×`ADDR_WIDTH`: per-channel address.
- `req_data_write`, in, `CHANNELS`×`DATA_WIDTH`: per-channel write data.
- `req_ready`, out, `CHANNELS`: one-cycle completion pulse to the granted channel.
- `req_error`, out, 1: qualifies `req_ready`; 1 = timed out.
- `req_data_read`, out, `DATA_WIDTH`: read data, shared by all channels, valid while `req_ready` is set.
- `mem_vaild`, out, 1: memory request.
- `mem_ready`, in, 1: memory completion.
- `mem_write_enable`, out, 1: write (1) / read (0) to memory.
- `mem_address`, out, `ADDR_WIDTH`: memory address.
- `mem_data_write`, out, `DATA_WIDTH`: memory write data.
- `mem_data_read`, in, `DATA_WIDTH`: memory read data.
- `bus_busy`, out, 1: 1 whenever the controller is not in IDLE.

## Operation

States: IDLE, ISSUE, RESPOND.

- **IDLE**
  - If any `req_vaild` bit is set, the arbiter grants one channel.
  - The granted channel's write-enable, address and write data are latched into `mem_*`.
  - The grant index is latched and the timeout counter is cleared; next state is ISSUE.
  - With no request, the controller stays in IDLE.
- **ISSUE**
  - `mem_vaild` = 1, and `mem_*` holds the latched values.
  - `mem_ready` = 1 at an edge: capture `mem_data_read` (reads) or 0 (writes) into `req_data_read`, set error = 0, go to RESPOND.
  - Otherwise, if `TIMEOUT`≠0 and the counter equals `TIMEOUT`: set error = 1, `req_data_read` = 0, go to RESPOND.
  - Otherwise the counter increments, saturating at `TIMEOUT`.
- **RESPOND**
  - `req_ready[grant]` = 1 for exactly one cycle, with `req_error` = error and `mem_vaild` = 0.
  - Next state is IDLE unconditionally.
- **Round-robin arbitration**
  - Priority starts at `last_grant`+1 (mod `CHANNELS`) and moves upward.
  - `last_grant` updates only on a grant.
  - Reset value of `last_grant` is `CHANNELS`-1, so channel 0 wins first.
- **Requester rules**
  - Hold `req_vaild` and the request fields until `req_ready`.
  - Field changes after the grant cycle are ignored.
  - Deassert `req_vaild` in the cycle after `req_ready`; a `req_vaild` still high in IDLE is treated as a new request.
- **Memory side**
  - `mem_ready` is ignored outside ISSUE.
  - A `mem_ready` arriving in the same cycle the counter reaches `TIMEOUT` wins: normal completion, error = 0.
- **Reset**
  - Asserting `reset` at any time, including mid-ISSUE, forces IDLE immediately.
  - All outputs go to 0, counter = 0, `last_grant` = `CHANNELS`-1.
  - The aborted transaction receives no `req_ready`.

## Timing

- Reset values: `req_ready` = 0, `req_error` = 0, `req_data_read` = 0, `mem_vaild` = 0, `mem_write_enable` = 0, `mem_address` = 0, `mem_data_write` = 0, `bus_busy` = 0.
- All outputs are registered; there are no combinational input→output paths.
- Request → memory: `req_vaild` high in cycle 0 (IDLE) → `mem_vaild` high in cycle 1.
- Memory → response: `mem_ready` high in cycle k (ISSUE) → `req_ready` high in cycle k+1.
- Minimum transaction is 3 cycles: request in cycle 0, `req_ready` in cycle 2, next grant possible in cycle 3.
- Timeout: with no `mem_ready`, ISSUE lasts `TIMEOUT`+1 cycles, then `req_ready` with `req_error` = 1.
- With `TIMEOUT` = 0, ISSUE waits indefinitely.
- Throughput: at most one transaction per 3 cycles.

## Structure

- Package `bus_pkg`:
  - state enum `bus_state_t` (IDLE, ISSUE, RESPOND);
  - struct `bus_request_t` (write_enable, address, data_write), parametrised through localparam widths.
- Sub-module `round_robin_arbiter`:
  - parameter `CHANNELS`;
  - inputs: `request` vector, `last_grant` index, `enable`;
  - outputs: `grant_valid`, `grant_index`;
  - purely combinational.
- `last_grant`, state, counter and the latched request live in `bus_controller_rr`.

## Test plan

- **Single read:** `CHANNELS`=2; ch0 reads 0x0000_0010; memory answers `mem_ready` 2 cycles after `mem_vaild` with 0xABCD_EF01 → `mem_address` = 0x10, `req_ready[0]` pulses once with `req_data_read` = 0xABCD_EF01, `req_error` = 0.
- **Round-robin fairness:** ch0 and ch1 request continuously; memory answers immediately → grants alternate 0,1,0,1, one per 3 cycles; ch0 goes first after reset.
- **Write:** ch1 writes 0x1234_5678 to 0x20 → `mem_write_enable` = 1, `mem_data_write` = 0x1234_5678; `req_data_read` = 0 on `req_ready[1]`.
- **Timeout:** `TIMEOUT`=4; `mem_ready` held low → `mem_vaild` high 5 cycles, then `req_ready[0]` with `req_error` = 1 and `req_data_read` = 0. Repeat with `mem_ready` on the 5th ISSUE cycle → `req_error` = 0.
- **Reset mid-transaction:** `reset` driven low during ISSUE → `mem_vaild`, `bus_busy` and `req_ready` go to 0 immediately; after release, ch0 wins first even if ch1 was granted before the reset.
- **Stability:** change `req_address` after the grant → `mem_address` keeps the latched value.
